ring_evt_buf: RTL and testbench
===============================

Name: ring_evt_buf

Overview:
Parametrised successor to the per-channel ring buffer in the DCFEB sample path. Continuously stores ADC words plus overlap tags in a circular RAM and queues L1A-matched start pointers in an internal FIFO. An in-block readout FSM extracts SAMP_MAX-word events, with downstream backpressure, occupancy monitoring and a sticky overrun flag. Sits between the sample/L1A logic and the event-builder FIFO.

Parameters:
DATA_W, 12, ADC sample width
TAG_W, 7, overlap tag width written alongside each sample ({movlp,ovlp,ocnt[4:0]})
ADDR_W, 12, ring address width; depth = 2**ADDR_W
QDEPTH_LOG2, 4, L1A queue depth = 2**QDEPTH_LOG2
EVT_W, 36, L1A event info width ({l1amcnt[11:0], l1acnt[23:0]})
WARN_LVL, 4000, occupancy threshold for WARN

Ports:
CLK  in  1  single clock, all logic on rising edge
RST_RESYNC  in  1  asynchronous, active-high reset
SAMP_MAX  in  7  words per event; 0 treated as 1; sampled at event start
WDATA  in  DATA_W  sample word
WTAG  in  TAG_W  overlap tag for this sample
WREN  in  1  write WDATA/WTAG at write pointer
L1A_WRT_EN  in  1  L1A sample strobe
L1A_MATCH  in  1  L1A match qualifier; push only when L1A_WRT_EN & L1A_MATCH
L1A_PHASE  in  1  L1A phase bit carried with event
L1A_INFO  in  EVT_W  event counters carried with event
DATA_AFULL  in  1  downstream almost-full; stalls reads
L1A_EVT_DATA  out  EVT_W+1  {phase, info} of event being read
L1A_EVT_PUSH  out  1  one-cycle strobe when L1A_EVT_DATA updates
RDATA  out  TAG_W+DATA_W  {tag, sample} readout word
DATA_PUSH  out  1  RDATA valid strobe
EVT_DONE  out  1  one-cycle strobe after last word of event issued
WARN  out  1  occupancy > WARN_LVL
RING_ERR  out  1  sticky overrun flag
Q_OVF  out  1  sticky L1A-queue drop flag
QCNT  out  QDEPTH_LOG2+1  queued L1A count

Behaviour:
- Reset: all pointers, counters and QCNT = 0; FSM IDLE; every output 0; RAM contents undefined, not cleared.
- Write: on WREN, RAM[wp] <= {WTAG,WDATA}; wp <= wp+1 mod 2**ADDR_W. Always accepted.
- L1A push: queue entry {L1A_PHASE, wp, L1A_INFO}, where wp is the value before any same-cycle WREN increment. If the queue is full, drop the entry, set Q_OVF, leave QCNT unchanged.
- Simultaneous push and pop: QCNT unchanged.
- Protected pointer pp: rp while FSM is in READ/DRAIN; else head start address if the queue is non-empty; else wp.
- Occupancy occ = (wp - pp) mod 2**ADDR_W, computed ADDR_W+1 wide.
- WARN is combinational from occ.
- RING_ERR sets when WREN occurs with occ == 2**ADDR_W-1; clears only on reset. Data are still written.
- FSM IDLE: if queue non-empty, go to LOAD.
- FSM LOAD (1 cycle):
  - Pop the queue.
  - rp <= start.
  - len <= max(SAMP_MAX,1).
  - Latch L1A_EVT_DATA; pulse L1A_EVT_PUSH.
  - Go to READ.
- FSM READ: issue a read when all hold: !DATA_AFULL; avail = (wp-rp) mod depth >= 1; len > 0.
  - Each issue: rp+1 mod depth, len-1.
  - A read never overtakes wp; it waits for samples still being written.
  - When the last word is issued: pulse EVT_DONE, go to DRAIN.
- FSM DRAIN (2 cycles, flushes the read pipe): then IDLE, or LOAD directly if the queue is non-empty.
- Read latency: DATA_PUSH and RDATA are valid exactly 2 cycles after read issue (RAM address register + output register). A DATA_AFULL assertion does not cancel words already in flight.
- Wrap: rp and wp roll over from 2**ADDR_W-1 to 0 silently.
- Reset mid-event: abort immediately; queue emptied; no DATA_PUSH after reset release until a new L1A is pushed.

Optional Feature:
RING_PARITY_EN:
- Defined: RAM is 1 bit wider; write stores even parity over {WTAG,WDATA}. Readout checks parity and adds output PAR_ERR (1-cycle, aligned with DATA_PUSH) plus sticky PAR_ERR_STKY (cleared by reset).
- Undefined: no extra RAM bit, no parity ports.

Test Plan:
- Write 20 words (WDATA=0x100+i); L1A push at wp=5; SAMP_MAX=8 -> L1A_EVT_PUSH once; DATA_PUSH x8 with RDATA[11:0]=0x105..0x10C; then EVT_DONE; QCNT returns to 0.
- L1A push at wp=4090, SAMP_MAX=10, writes continuing -> words read from addresses 4090..4095,0..3 in order; no RING_ERR.
- L1A push with only 2 words written past start, SAMP_MAX=6 -> 2 DATA_PUSH, stall, remaining 4 follow the subsequent writes, each 2 cycles after its issue.
- DATA_AFULL high for 10 cycles mid-event -> at most 2 DATA_PUSH after assertion, none during the rest, resume on release, total count exact.
- 17 L1A pushes back-to-back with QDEPTH_LOG2=4, reads stalled -> QCNT=16, Q_OVF=1, the 17th entry never read.
- Hold an event unread (DATA_AFULL high) and write 4095 more words -> WARN above 4000, RING_ERR=1 on the overrun write, persists until RST_RESYNC.

Source files
------------

// File: rtl/ring_evt_buf.sv
// ring_evt_buf: circular sample RAM with L1A start-pointer queue and event readout FSM.
// Optional RING_PARITY_EN adds a parity bit per RAM word plus PAR_ERR / PAR_ERR_STKY outputs.
//
// Ports:
//   CLK, RST_RESYNC        clock, asynchronous active-high reset
//   SAMP_MAX               words per event (0 -> 1), sampled when an event is loaded
//   WDATA, WTAG, WREN      sample write port, always accepted at the write pointer
//   L1A_WRT_EN, L1A_MATCH  push {L1A_PHASE, wp, L1A_INFO} into the queue when both are high
//   DATA_AFULL             downstream almost-full, holds off new read issues
//   L1A_EVT_DATA/_PUSH     {phase, info} of the event being read, strobe on update
//   RDATA, DATA_PUSH       {tag, sample} readout word, two cycles after issue
//   EVT_DONE               strobe after the last word of an event is issued
//   WARN, RING_ERR, Q_OVF  occupancy warning, sticky ring overrun, sticky queue drop
//   QCNT                   number of queued L1A entries
module ring_evt_buf #(
   parameter int DATA_W      = 12,
   parameter int TAG_W       = 7,
   parameter int ADDR_W      = 12,
   parameter int QDEPTH_LOG2 = 4,
   parameter int EVT_W       = 36,
   parameter int WARN_LVL    = 4000
) (
   input  logic                     CLK,
   input  logic                     RST_RESYNC,
   input  logic [6:0]               SAMP_MAX,
   input  logic [DATA_W-1:0]        WDATA,
   input  logic [TAG_W-1:0]         WTAG,
   input  logic                     WREN,
   input  logic                     L1A_WRT_EN,
   input  logic                     L1A_MATCH,
   input  logic                     L1A_PHASE,
   input  logic [EVT_W-1:0]         L1A_INFO,
   input  logic                     DATA_AFULL,
   output logic [EVT_W:0]           L1A_EVT_DATA,
   output logic                     L1A_EVT_PUSH,
   output logic [TAG_W+DATA_W-1:0]  RDATA,
   output logic                     DATA_PUSH,
   output logic                     EVT_DONE,
   output logic                     WARN,
   output logic                     RING_ERR,
   output logic                     Q_OVF,
`ifdef RING_PARITY_EN
   output logic                     PAR_ERR,
   output logic                     PAR_ERR_STKY,
`endif
   output logic [QDEPTH_LOG2:0]     QCNT
);

   localparam int DW    = TAG_W + DATA_W;
`ifdef RING_PARITY_EN
   localparam int RW    = DW + 1;
`else
   localparam int RW    = DW;
`endif
   localparam int QW    = 1 + ADDR_W + EVT_W;
   localparam int QD    = 2**QDEPTH_LOG2;
   localparam int DEPTH = 2**ADDR_W;

   localparam logic [ADDR_W:0] WARN_THR = WARN_LVL[ADDR_W:0];

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [RW-1:0]          mem [DEPTH];
   logic [QW-1:0]          q_mem [QD];

   logic [ADDR_W-1:0]      wp;
   logic [ADDR_W-1:0]      rp;
   logic [ADDR_W-1:0]      pp;
   logic [ADDR_W-1:0]      rd_addr;
   logic [ADDR_W-1:0]      occ_w;
   logic [ADDR_W:0]        occ;
   logic [QDEPTH_LOG2-1:0] q_wp;
   logic [QDEPTH_LOG2-1:0] q_rp;
   logic [QW-1:0]          q_head;
   logic                   q_empty;
   logic                   q_full;
   logic                   q_push_req;
   logic                   q_push;
   logic                   q_pop;
   logic [1:0]             state;
   logic [6:0]             len;
   logic                   drain_cnt;
   logic                   avail;
   logic                   issue;
   logic                   rd_v;
   logic [RW-1:0]          wr_word;
   logic [RW-1:0]          ram_q;

`ifdef RING_PARITY_EN
   assign wr_word = {^{WTAG, WDATA}, WTAG, WDATA};
`else
   assign wr_word = {WTAG, WDATA};
`endif

   assign q_head     = q_mem[q_rp];
   assign q_empty    = (QCNT == '0);
   // count never exceeds QD, so the MSB alone marks full
   assign q_full     = QCNT[QDEPTH_LOG2];
   assign q_push_req = L1A_WRT_EN & L1A_MATCH;
   assign q_push     = q_push_req & ~q_full;
   assign q_pop      = (state == S_LOAD);

   // oldest sample that must not be overwritten
   always_comb begin
      pp = wp;
      if (state == S_READ || state == S_DRAIN)
         pp = rp;
      else if (!q_empty)
         pp = q_head[EVT_W +: ADDR_W];
   end

   assign occ_w = wp - pp;
   assign occ   = {1'b0, occ_w};
   assign WARN  = (occ > WARN_THR);

   // read may never pass the write pointer
   assign avail = (wp != rp);
   assign issue = (state == S_READ) && !DATA_AFULL && avail && (len != '0);

   assign ram_q = mem[rd_addr];

   always_ff @(posedge CLK) begin
      if (WREN)
         mem[wp] <= wr_word;
   end

   always_ff @(posedge CLK) begin
      if (q_push)
         q_mem[q_wp] <= {L1A_PHASE, wp, L1A_INFO};
   end

   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         wp       <= '0;
         RING_ERR <= 1'b0;
      end else if (WREN) begin
         wp <= wp + ADDR_W'(1);
         if (occ_w == '1)
            RING_ERR <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         q_wp  <= '0;
         q_rp  <= '0;
         QCNT  <= '0;
         Q_OVF <= 1'b0;
      end else begin
         if (q_push)
            q_wp <= q_wp + QDEPTH_LOG2'(1);
         if (q_pop)
            q_rp <= q_rp + QDEPTH_LOG2'(1);
         if (q_push_req && q_full)
            Q_OVF <= 1'b1;
         case ({q_push, q_pop})
            2'b10:   QCNT <= QCNT + (QDEPTH_LOG2+1)'(1);
            2'b01:   QCNT <= QCNT - (QDEPTH_LOG2+1)'(1);
            default: QCNT <= QCNT;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         state        <= S_IDLE;
         rp           <= '0;
         len          <= '0;
         drain_cnt    <= 1'b0;
         L1A_EVT_DATA <= '0;
         L1A_EVT_PUSH <= 1'b0;
         EVT_DONE     <= 1'b0;
      end else begin
         L1A_EVT_PUSH <= 1'b0;
         EVT_DONE     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!q_empty)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               rp           <= q_head[EVT_W +: ADDR_W];
               len          <= (SAMP_MAX == '0) ? 7'd1 : SAMP_MAX;
               L1A_EVT_DATA <= {q_head[QW-1], q_head[EVT_W-1:0]};
               L1A_EVT_PUSH <= 1'b1;
               state        <= S_READ;
            end
            S_READ: begin
               if (issue) begin
                  rp  <= rp + ADDR_W'(1);
                  len <= len - 7'd1;
                  if (len == 7'd1) begin
                     EVT_DONE  <= 1'b1;
                     drain_cnt <= 1'b0;
                     state     <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // two cycles let the last words leave the read pipe
               if (!drain_cnt)
                  drain_cnt <= 1'b1;
               else
                  state <= q_empty ? S_IDLE : S_LOAD;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // stage 1: address register, stage 2: output register
   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         rd_v      <= 1'b0;
         rd_addr   <= '0;
         DATA_PUSH <= 1'b0;
         RDATA     <= '0;
      end else begin
         rd_v      <= issue;
         DATA_PUSH <= rd_v;
         if (issue)
            rd_addr <= rp;
         if (rd_v)
            RDATA <= ram_q[DW-1:0];
      end
   end

`ifdef RING_PARITY_EN
   always_ff @(posedge CLK or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
         PAR_ERR      <= 1'b0;
         PAR_ERR_STKY <= 1'b0;
      end else begin
         PAR_ERR <= rd_v & (^ram_q);
         if (rd_v && (^ram_q))
            PAR_ERR_STKY <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ring_evt_buf.sv
// tb_ring_evt_buf: directed bench for ring_evt_buf.
// Covers readout, wrap, stall on empty ring, backpressure, queue overflow, WARN/RING_ERR.
module tb_ring_evt_buf;

   logic        CLK = 1'b0;
   logic        RST_RESYNC;
   logic [6:0]  SAMP_MAX;
   logic [11:0] WDATA;
   logic [6:0]  WTAG;
   logic        WREN;
   logic        L1A_WRT_EN;
   logic        L1A_MATCH;
   logic        L1A_PHASE;
   logic [35:0] L1A_INFO;
   logic        DATA_AFULL;
   logic [36:0] L1A_EVT_DATA;
   logic        L1A_EVT_PUSH;
   logic [18:0] RDATA;
   logic        DATA_PUSH;
   logic        EVT_DONE;
   logic        WARN;
   logic        RING_ERR;
   logic        Q_OVF;
   logic [4:0]  QCNT;
`ifdef RING_PARITY_EN
   logic        PAR_ERR;
   logic        PAR_ERR_STKY;
`endif

   ring_evt_buf dut (
      .CLK          (CLK),
      .RST_RESYNC   (RST_RESYNC),
      .SAMP_MAX     (SAMP_MAX),
      .WDATA        (WDATA),
      .WTAG         (WTAG),
      .WREN         (WREN),
      .L1A_WRT_EN   (L1A_WRT_EN),
      .L1A_MATCH    (L1A_MATCH),
      .L1A_PHASE    (L1A_PHASE),
      .L1A_INFO     (L1A_INFO),
      .DATA_AFULL   (DATA_AFULL),
      .L1A_EVT_DATA (L1A_EVT_DATA),
      .L1A_EVT_PUSH (L1A_EVT_PUSH),
      .RDATA        (RDATA),
      .DATA_PUSH    (DATA_PUSH),
      .EVT_DONE     (EVT_DONE),
      .WARN         (WARN),
      .RING_ERR     (RING_ERR),
      .Q_OVF        (Q_OVF),
`ifdef RING_PARITY_EN
      .PAR_ERR      (PAR_ERR),
      .PAR_ERR_STKY (PAR_ERR_STKY),
`endif
      .QCNT         (QCNT)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int n_done = 0;
   int bwp    = 0;

   logic [18:0] rq[$];
   int          pc[$];
   logic [36:0] eq[$];

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (!RST_RESYNC) begin
         if (DATA_PUSH) begin
            rq.push_back(RDATA);
            pc.push_back(cyc);
         end
         if (EVT_DONE)
            n_done = n_done + 1;
         if (L1A_EVT_PUSH)
            eq.push_back(L1A_EVT_DATA);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (got === exp)
         n_pass = n_pass + 1;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [11:0] d, input logic [6:0] t, input logic l1a);
      WDATA      = d;
      WTAG       = t;
      WREN       = 1'b1;
      L1A_WRT_EN = l1a;
      L1A_MATCH  = l1a;
      tick();
      WREN       = 1'b0;
      L1A_WRT_EN = 1'b0;
      L1A_MATCH  = 1'b0;
      bwp        = (bwp + 1) % 4096;
   endtask

   task automatic wait_done(input int target, input string tag);
      for (int i = 0; i < 400 && n_done < target; i++)
         tick();
      chk(tag, n_done, target);
   endtask

   logic [18:0] w;
   int wcyc[6];
   int n0, n3, n10;

   initial begin
      RST_RESYNC = 1'b1;
      SAMP_MAX   = 7'd8;
      WDATA      = '0;
      WTAG       = '0;
      WREN       = 1'b0;
      L1A_WRT_EN = 1'b0;
      L1A_MATCH  = 1'b0;
      L1A_PHASE  = 1'b0;
      L1A_INFO   = '0;
      DATA_AFULL = 1'b0;
      repeat (3) tick();
      RST_RESYNC = 1'b0;
      tick();
      chk("rst_qcnt", QCNT, 0);
      chk("rst_push", DATA_PUSH, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_evtdata", L1A_EVT_DATA, 0);
      chk("rst_flags", {WARN, RING_ERR, Q_OVF, EVT_DONE, L1A_EVT_PUSH}, 0);

      // basic event: start at wp=5, 8 words
      L1A_PHASE = 1'b1;
      L1A_INFO  = 36'h123456789;
      for (int i = 0; i < 20; i++)
         wr(12'(12'h100 + i), 7'(i), i == 5);
      wait_done(1, "t1_done");
      repeat (5) tick();
      chk("t1_evtpush_cnt", eq.size(), 1);
      chk("t1_evtdata", eq[0], {1'b1, 36'h123456789});
      chk("t1_nwords", rq.size(), 8);
      for (int k = 0; k < 8 && k < rq.size(); k++)
         chk("t1_word", rq[k], {7'(5 + k), 12'(12'h105 + k)});
      chk("t1_qcnt", QCNT, 0);

      // wrap across the top of the ring
      while (bwp != 4090)
         wr(12'hAAA, 7'd0, 1'b0);
      rq.delete();
      SAMP_MAX  = 7'd10;
      L1A_PHASE = 1'b0;
      L1A_INFO  = 36'd2;
      for (int i = 0; i < 16; i++)
         wr(12'(12'h200 + i), 7'(i), i == 0);
      wait_done(2, "t2_done");
      repeat (5) tick();
      chk("t2_nwords", rq.size(), 10);
      for (int k = 0; k < 10 && k < rq.size(); k++) begin
         w = rq[k];
         chk("t2_word", w[11:0], 12'(12'h200 + k));
      end
      chk("t2_ringerr", RING_ERR, 0);

      // reads wait for samples still being written
      rq.delete();
      pc.delete();
      SAMP_MAX = 7'd6;
      wr(12'h300, 7'd0, 1'b1);
      wr(12'h301, 7'd1, 1'b0);
      repeat (10) tick();
      chk("t3_stall_words", rq.size(), 2);
      chk("t3_stall_done", n_done, 2);
      for (int i = 2; i < 6; i++) begin
         wcyc[i] = cyc;
         wr(12'(12'h300 + i), 7'(i), 1'b0);
         repeat (2) tick();
      end
      wait_done(3, "t3_done");
      repeat (5) tick();
      chk("t3_nwords", rq.size(), 6);
      for (int k = 0; k < 6 && k < rq.size(); k++) begin
         w = rq[k];
         chk("t3_word", w[11:0], 12'(12'h300 + k));
      end
      for (int k = 2; k < 6 && k < pc.size(); k++)
         chk("t3_latency", pc[k] - wcyc[k], 3);

      // backpressure mid-event
      rq.delete();
      DATA_AFULL = 1'b1;
      SAMP_MAX   = 7'd20;
      for (int i = 0; i < 30; i++)
         wr(12'(12'h400 + i), 7'(i), i == 0);
      DATA_AFULL = 1'b0;
      for (int i = 0; i < 50 && rq.size() < 5; i++)
         tick();
      DATA_AFULL = 1'b1;
      n0 = rq.size();
      repeat (3) tick();
      n3 = rq.size();
      repeat (7) tick();
      n10 = rq.size();
      chk("t4_inflight_le2", (n3 - n0) <= 2, 1);
      chk("t4_quiet", n10, n3);
      DATA_AFULL = 1'b0;
      wait_done(4, "t4_done");
      repeat (5) tick();
      chk("t4_nwords", rq.size(), 20);
      for (int k = 0; k < 20 && k < rq.size(); k++) begin
         w = rq[k];
         chk("t4_word", w[11:0], 12'(12'h400 + k));
      end

      // queue overflow with the reader stalled
      eq.delete();
      DATA_AFULL = 1'b1;
      SAMP_MAX   = 7'd1;
      L1A_INFO   = 36'd100;
      wr(12'h500, 7'd0, 1'b1);
      repeat (4) tick();
      chk("t5_qcnt0", QCNT, 0);
      for (int i = 0; i < 16; i++) begin
         L1A_INFO = 36'(i);
         wr(12'(12'h510 + i), 7'd0, 1'b1);
      end
      chk("t5_qcnt16", QCNT, 16);
      chk("t5_ovf_before", Q_OVF, 0);
      L1A_INFO = 36'd16;
      wr(12'h520, 7'd0, 1'b1);
      chk("t5_qcnt_full", QCNT, 16);
      chk("t5_ovf", Q_OVF, 1);
      DATA_AFULL = 1'b0;
      wait_done(21, "t5_done");
      repeat (10) tick();
      chk("t5_nevt", eq.size(), 17);
      if (eq.size() == 17) begin
         chk("t5_first", eq[0][35:0], 100);
         chk("t5_last", eq[16][35:0], 15);
      end
      chk("t5_qcnt_end", QCNT, 0);
      chk("t5_ovf_sticky", Q_OVF, 1);

      // occupancy warning and overrun
      DATA_AFULL = 1'b1;
      SAMP_MAX   = 7'd8;
      wr(12'h600, 7'd0, 1'b1);
      repeat (3999) wr(12'h601, 7'd0, 1'b0);
      chk("t6_warn_4000", WARN, 0);
      wr(12'h602, 7'd0, 1'b0);
      chk("t6_warn_4001", WARN, 1);
      repeat (94) wr(12'h603, 7'd0, 1'b0);
      chk("t6_noerr_4095", RING_ERR, 0);
      wr(12'h604, 7'd0, 1'b0);
      chk("t6_ringerr", RING_ERR, 1);
      repeat (5) tick();
      chk("t6_ringerr_sticky", RING_ERR, 1);
      L1A_WRT_EN = 1'b1;
      L1A_MATCH  = 1'b1;
      tick();
      L1A_WRT_EN = 1'b0;
      L1A_MATCH  = 1'b0;
      chk("t6_qcnt1", QCNT, 1);

      // reset mid-event
      RST_RESYNC = 1'b1;
      tick();
      chk("t6_rst_ringerr", RING_ERR, 0);
      chk("t6_rst_qcnt", QCNT, 0);
      chk("t6_rst_flags", {WARN, Q_OVF, DATA_PUSH}, 0);
      chk("t6_rst_evtdata", L1A_EVT_DATA, 0);
      RST_RESYNC = 1'b0;
      DATA_AFULL = 1'b0;
      rq.delete();
      bwp = 0;
      repeat (10) wr(12'h700, 7'd0, 1'b0);
      repeat (10) tick();
      chk("t6_no_push", rq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
